// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Holds the default bus widths, the arbiter FSM state encoding and the
// write-enable / reset active levels used across the arbiter files.
package regfile_wr_arbiter_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic WE_ON      = 1'b1;
  localparam logic WE_OFF     = 1'b0;
  localparam logic RST_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bus bundle between the pipeline/long-latency unit, the arbiter and the
// register file write port.
//   a_*       : pipeline writeback (never back-pressured)
//   b_*       : long-latency result with valid/ready handshake
//   rf_*      : registered write to the register file
//   stall_req : asks the pipeline to hold its writeback this cycle
//   pend_*    : holding-buffer status for hazard checks
// The slave modport is the arbiter's view; master is the environment's view.
interface regfile_wr_arbiter_if
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_waddr;
  logic [DATA_W-1:0] b_wdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              stall_req;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_waddr;

  modport slave (
    input  a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    output b_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_valid, pend_waddr
  );

  modport master (
    output a_we, a_waddr, a_wdata, b_valid, b_waddr, b_wdata,
    input  b_ready, rf_we, rf_waddr, rf_wdata, stall_req, pend_valid, pend_waddr
  );
endinterface

// File: rtl/regfile_wr_holdbuf.sv
// One-entry holding register for a port-B write that lost arbitration.
// Ports: clk/rst, load (capture in_*), clear (free the entry),
// in_waddr/in_wdata (write to park), valid/waddr/wdata (parked entry).
// Load takes priority over clear; the arbiter never asserts both.
module regfile_wr_holdbuf
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              valid,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  // Entry storage. A reset discards whatever was parked, so the write
  // never reaches the register file afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      valid <= 1'b0;
      waddr <= '0;
      wdata <= '0;
    end else if (load) begin
      valid <= 1'b1;
      waddr <= in_waddr;
      wdata <= in_wdata;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file's single write port between pipeline writeback
// (port A, always wins) and a long-latency result (port B, valid/ready).
// A losing B write is parked in a one-entry buffer; if A keeps winning for
// MAX_WAIT cycles the FSM spends one FORCE cycle stalling the pipeline so
// the parked write drains. The selected write is registered onto rf_*.
// Ports: clk, rst (async, active-high), bus (slave side of the arbiter
// interface carrying ports A/B, rf_*, stall_req and pend_*).
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wr_arbiter_if.slave  bus
);

  localparam int                CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_WAIT);

  arb_state_t        state;
  arb_state_t        state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  cnt_next;

  logic              sel_valid;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;

  logic              buf_load;
  logic              buf_clear;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_waddr;
  logic [DATA_W-1:0] buf_wdata;

  logic              b_ready_c;
  logic              stall_req_c;
  logic              pend_valid_c;
  logic [ADDR_W-1:0] pend_waddr_c;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  regfile_wr_holdbuf #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_holdbuf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load),
    .clear    (buf_clear),
    .in_waddr (bus.b_waddr),
    .in_wdata (bus.b_wdata),
    .valid    (buf_valid),
    .waddr    (buf_waddr),
    .wdata    (buf_wdata)
  );

  // State register and starvation counter. The counter holds how many
  // cycles the parked write has been passed over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  // Next-state logic and write selection. Port B can only be taken in
  // IDLE, which is also the only state where the buffer is empty, so a
  // collision always has somewhere to park the B write. In FORCE the
  // buffer goes out unconditionally and a_we is ignored because the
  // pipeline is stalled and will re-present its write.
  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    sel_valid  = 1'b0;
    sel_waddr  = '0;
    sel_wdata  = '0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.a_we) begin
          sel_valid = 1'b1;
          sel_waddr = bus.a_waddr;
          sel_wdata = bus.a_wdata;
          if (bus.b_valid) begin
            buf_load   = 1'b1;
            cnt_next   = CNT_ONE;
            state_next = (MAX_WAIT == 1) ? ST_FORCE : ST_HOLD;
          end
        end else if (bus.b_valid) begin
          sel_valid = 1'b1;
          sel_waddr = bus.b_waddr;
          sel_wdata = bus.b_wdata;
        end
      end
      ST_HOLD: begin
        if (bus.a_we) begin
          sel_valid = 1'b1;
          sel_waddr = bus.a_waddr;
          sel_wdata = bus.a_wdata;
          cnt_next  = wait_cnt + CNT_ONE;
          if (cnt_next == MAX_CNT) begin
            state_next = ST_FORCE;
          end
        end else begin
          sel_valid  = 1'b1;
          sel_waddr  = buf_waddr;
          sel_wdata  = buf_wdata;
          buf_clear  = 1'b1;
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      ST_FORCE: begin
        sel_valid  = 1'b1;
        sel_waddr  = buf_waddr;
        sel_wdata  = buf_wdata;
        buf_clear  = 1'b1;
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state, plus buffer status.
  // The pending address reads as zero whenever nothing is parked.
  always_comb begin
    b_ready_c    = (state == ST_IDLE);
    stall_req_c  = (state == ST_FORCE);
    pend_valid_c = buf_valid;
    pend_waddr_c = buf_valid ? buf_waddr : '0;
  end

  // Registered write stage. Writes to x0 are consumed but never enabled,
  // and idle cycles drive a clean all-zero write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ACTIVE) begin
      rf_we_q    <= WE_OFF;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else if (sel_valid && (sel_waddr != '0)) begin
      rf_we_q    <= WE_ON;
      rf_waddr_q <= sel_waddr;
      rf_wdata_q <= sel_wdata;
    end else begin
      rf_we_q    <= WE_OFF;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end
  end

  assign bus.b_ready    = b_ready_c;
  assign bus.stall_req  = stall_req_c;
  assign bus.pend_valid = pend_valid_c;
  assign bus.pend_waddr = pend_waddr_c;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed scenarios plus a randomized
// run. Each driven cycle steps a queue-based reference model that pushes
// the expected register-file write; a separate monitor pops one entry per
// cycle and compares it with rf_*.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  exp_t expq[$];
  exp_t parked[$];
  int   age = 0;

  regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_wr_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of inputs, check the combinational outputs against the
  // model's view of the parked write, then let the model decide which write
  // the arbiter takes this cycle. A parked write leaves when A is idle or
  // once it has been passed over MAX_WAIT times (A is then held back).
  task automatic applyStimulus(input bit awe, input logic [4:0] aaddr, input logic [31:0] adata,
                               input bit bv, input logic [4:0] baddr, input logic [31:0] bdata,
                               output bit a_acc, output bit b_acc);
    exp_t e;
    exp_t w;
    bit   sel;
    @(posedge clk);
    #2;
    bus.a_we    = awe;
    bus.a_waddr = aaddr;
    bus.a_wdata = adata;
    bus.b_valid = bv;
    bus.b_waddr = baddr;
    bus.b_wdata = bdata;
    #1;
    checkOutput("b_ready", 32'(bus.b_ready), 32'(parked.size() == 0));
    checkOutput("stall_req", 32'(bus.stall_req), 32'(parked.size() != 0 && age >= MAX_WAIT));
    checkOutput("pend_valid", 32'(bus.pend_valid), 32'(parked.size() != 0));
    if (parked.size() != 0) checkOutput("pend_waddr", 32'(bus.pend_waddr), 32'(parked[0].addr));
    a_acc = 1'b0;
    b_acc = 1'b0;
    sel   = 1'b0;
    w     = '0;
    if (parked.size() != 0) begin
      if (age >= MAX_WAIT || !awe) begin
        w   = parked.pop_front();
        sel = 1'b1;
        age = 0;
      end else begin
        w     = '{we: 1'b1, addr: aaddr, data: adata};
        sel   = 1'b1;
        a_acc = 1'b1;
        age   = age + 1;
      end
    end else begin
      b_acc = bv;
      if (awe) begin
        w     = '{we: 1'b1, addr: aaddr, data: adata};
        sel   = 1'b1;
        a_acc = 1'b1;
        if (bv) begin
          parked.push_back('{we: 1'b1, addr: baddr, data: bdata});
          age = 1;
        end
      end else if (bv) begin
        w   = '{we: 1'b1, addr: baddr, data: bdata};
        sel = 1'b1;
      end
    end
    e.we   = sel && (w.addr != 5'd0);
    e.addr = e.we ? w.addr : 5'd0;
    e.data = e.we ? w.data : 32'd0;
    expq.push_back(e);
  endtask

  task automatic idleCycle();
    bit aa, ba;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, aa, ba);
  endtask

  // Monitor: one cycle after each driven cycle, rf_* must show the write
  // the model predicted; with nothing predicted, rf_we must be low.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        checkOutput("rf_we", 32'(bus.rf_we), 32'(e.we));
        if (e.we) begin
          checkOutput("rf_waddr", 32'(bus.rf_waddr), 32'(e.addr));
          checkOutput("rf_wdata", bus.rf_wdata, e.data);
        end
      end else begin
        checkOutput("rf_we_idle", 32'(bus.rf_we), 32'd0);
      end
    end
  end

  // Stimulus sequence: reset, directed scenarios, then random traffic.
  initial begin
    bit aa, ba;
    bit pa_we, pb_v, pa_pend, pb_pend;
    logic [4:0]  pa_addr, pb_addr;
    logic [31:0] pa_data, pb_data;

    rst = 1'b1;
    bus.a_we = 1'b1; bus.a_waddr = 5'd3; bus.a_wdata = 32'h11;
    bus.b_valid = 1'b0; bus.b_waddr = 5'd0; bus.b_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("rst_rf_we", 32'(bus.rf_we), 32'd0);
    checkOutput("rst_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    checkOutput("rst_rf_wdata", bus.rf_wdata, 32'd0);
    checkOutput("rst_stall", 32'(bus.stall_req), 32'd0);
    checkOutput("rst_pend_valid", 32'(bus.pend_valid), 32'd0);
    checkOutput("rst_pend_waddr", 32'(bus.pend_waddr), 32'd0);
    bus.a_we = 1'b0;
    rst = 1'b0;

    $display("[TB] first write after reset");
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, aa, ba);
    idleCycle();
    checkOutput("post_rst_we", 32'(bus.rf_we), 32'd1);
    checkOutput("post_rst_waddr", 32'(bus.rf_waddr), 32'd3);
    checkOutput("post_rst_wdata", bus.rf_wdata, 32'h11);

    $display("[TB] collision");
    applyStimulus(1'b1, 5'd4, 32'hAA, 1'b1, 5'd5, 32'hBB, aa, ba);
    checkOutput("coll_b_ready0", 32'(bus.b_ready), 32'd1);
    idleCycle();
    checkOutput("coll_pend_valid", 32'(bus.pend_valid), 32'd1);
    checkOutput("coll_pend_waddr", 32'(bus.pend_waddr), 32'd5);
    checkOutput("coll_b_ready1", 32'(bus.b_ready), 32'd0);
    checkOutput("coll_rf_a_addr", 32'(bus.rf_waddr), 32'd4);
    checkOutput("coll_rf_a_data", bus.rf_wdata, 32'hAA);
    idleCycle();
    checkOutput("coll_rf_b_addr", 32'(bus.rf_waddr), 32'd5);
    checkOutput("coll_rf_b_data", bus.rf_wdata, 32'hBB);
    idleCycle();

    $display("[TB] starvation");
    for (int c = 0; c < 7; c++) begin
      if (c == 0) applyStimulus(1'b1, 5'd6, 32'h600, 1'b1, 5'd7, 32'h700, aa, ba);
      else if (c < 6) applyStimulus(1'b1, 5'(8 + c), 32'h800 + c, 1'b0, 5'd0, 32'd0, aa, ba);
      else idleCycle();
      checkOutput("starve_stall", 32'(bus.stall_req), 32'(c == 4));
      if (c == 5) begin
        checkOutput("starve_b_ready", 32'(bus.b_ready), 32'd1);
        checkOutput("starve_rf_addr", 32'(bus.rf_waddr), 32'd7);
        checkOutput("starve_rf_data", bus.rf_wdata, 32'h700);
      end
    end

    $display("[TB] x0 drop");
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, aa, ba);
    checkOutput("x0_b_ready", 32'(bus.b_ready), 32'd1);
    idleCycle();
    checkOutput("x0_rf_we", 32'(bus.rf_we), 32'd0);

    $display("[TB] async reset mid-HOLD");
    applyStimulus(1'b1, 5'd9, 32'h900, 1'b1, 5'd10, 32'hA00, aa, ba);
    applyStimulus(1'b1, 5'd11, 32'hB00, 1'b0, 5'd0, 32'd0, aa, ba);
    #2;
    bus.a_we = 1'b0;
    bus.b_valid = 1'b0;
    rst = 1'b1;
    expq.delete();
    parked.delete();
    age = 0;
    #1;
    checkOutput("arst_pend_valid", 32'(bus.pend_valid), 32'd0);
    checkOutput("arst_rf_we", 32'(bus.rf_we), 32'd0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (3) idleCycle();

    $display("[TB] back-to-back B");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'h100 + i, aa, ba);
      checkOutput("b2b_b_ready", 32'(bus.b_ready), 32'd1);
    end
    idleCycle();

    $display("[TB] random traffic");
    pa_pend = 1'b0; pb_pend = 1'b0;
    pa_we = 1'b0; pb_v = 1'b0;
    pa_addr = '0; pb_addr = '0; pa_data = '0; pb_data = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pa_pend) begin
        pa_we   = ($urandom_range(0, 99) < 55);
        pa_addr = 5'($urandom_range(0, 7));
        pa_data = $urandom;
      end
      if (!pb_pend) begin
        pb_v    = ($urandom_range(0, 99) < 45);
        pb_addr = 5'($urandom_range(0, 31));
        pb_data = $urandom;
      end
      applyStimulus(pa_we, pa_addr, pa_data, pb_v, pb_addr, pb_data, aa, ba);
      pa_pend = pa_we && !aa;
      pb_pend = pb_v && !ba;
    end
    repeat (4) idleCycle();
    repeat (2) @(posedge clk);
    #2;
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
